// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I types for the MEM stage: opcodes, funct3 encodings,
// the control word carried down the pipe, and the LSU FSM states.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-cache request/response bundle between the MEM stage and the cache.
// Handshake: dmem_read/dmem_write are levels raised by the LSU and held with
// address/wdata/byte_enable stable until the cache returns a one-cycle
// dmem_resp; the transfer completes in the cycle dmem_resp is high, and
// dmem_rdata is only meaningful in that cycle.
interface mem_stage_lsu_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the cache word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import rv32i_types::*;
(
  input  logic [31:0]  rdata,
  input  logic [1:0]   offset,
  input  load_funct3_t funct3,
  output logic [31:0]  data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [1:0]  half_off;

  // Lane extraction and extension; a halfword at offset 3 would straddle
  // the word, so it is read from offset 0 instead.
  always_comb begin
    half_off = (offset == 2'd3) ? 2'd0 : offset;
    byte_sel = 8'(rdata >> {offset, 3'b000});
    half_sel = 16'(rdata >> {half_off, 3'b000});
    data     = '0;
    unique case (funct3)
      lb:      data = {{24{byte_sel[7]}}, byte_sel};
      lbu:     data = {24'd0, byte_sel};
      lh:      data = {{16{half_sel[15]}}, half_sel};
      lhu:     data = {16'd0, half_sel};
      lw:      data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues the cache request for the instruction
// held in EX/MEM, stalls the pipe until the cache responds, shifts store
// data into its lanes and aligns load data for MEM/WB.
module mem_stage_lsu
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  rv32i_control_word ctrl_in,
  input  logic              ext_stall,
  mem_stage_lsu_if.master   dmem,
  output logic [31:0]       load_data_out,
  output logic              mem_stall,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output lsu_state_t        state_dbg
);

  lsu_state_t  state_q, state_d;
  logic [31:0] held_q;
  logic [31:0] aligned;
  logic        is_load, is_store, mem_op;
  logic        req, accept;

  assign is_load  = (ctrl_in.opcode == op_load);
  assign is_store = (ctrl_in.opcode == op_store);
  assign mem_op   = is_load | is_store;
  assign state_dbg = state_q;

  lsu_load_align u_load_align (
    .rdata  (dmem.dmem_rdata),
    .offset (alu_in[1:0]),
    .funct3 (load_funct3_t'(ctrl_in.funct3)),
    .data   (aligned)
  );

  // Request bus is driven only while a request is live, so it reads all
  // zeros when idle or parked in DONE.
  assign dmem.dmem_read        = req & is_load;
  assign dmem.dmem_write       = req & is_store;
  assign dmem.dmem_address     = req ? {alu_in[31:2], 2'b00} : '0;
  assign dmem.dmem_wdata       = req ? (rs2_in << {alu_in[1:0], 3'b000}) : '0;
  assign dmem.dmem_byte_enable = req ? (is_store ? mem_byte_enable_in : 4'b1111) : '0;

  // State register; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, request, stall and load result; a response completes the
  // access in the same cycle, and DONE parks a frozen instruction so it is
  // not re-issued.
  always_comb begin
    state_d       = state_q;
    req           = 1'b0;
    accept        = 1'b0;
    mem_stall     = 1'b0;
    load_data_out = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          req = 1'b1;
          if (dmem.dmem_resp) begin
            accept  = 1'b1;
            state_d = ext_stall ? DONE : IDLE;
          end else begin
            mem_stall = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem.dmem_resp) begin
          accept  = 1'b1;
          state_d = ext_stall ? DONE : IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      DONE: begin
        load_data_out = held_q;
        if (!ext_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept && is_load) load_data_out = aligned;
  end

  // Holds the completed load result for as long as the pipe stays frozen.
  always_ff @(posedge clk) begin
    if (!rst)        held_q <= '0;
    else if (accept) held_q <= is_load ? aligned : '0;
  end

  // Saturating access and stall counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      access_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (accept && (access_cnt != '1)) access_cnt <= access_cnt + 1'b1;
      if (mem_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
